// File: rtl/select_pkg.sv
// Shared constants and FSM encoding for the selection-RAM scan sequencer.
package select_pkg;

  localparam int SEL_BINS  = 256;
  localparam int SEL_BYTES = 32;
  localparam int SEL_AW    = 8;
  localparam int SEL_CW    = $clog2(SEL_BINS) + 1;

  typedef logic [2:0] sel_state_t;

  localparam sel_state_t ST_IDLE     = 3'd0;
  localparam sel_state_t ST_CFG      = 3'd1;
  localparam sel_state_t ST_WAIT_RDY = 3'd2;
  localparam sel_state_t ST_READ     = 3'd3;
  localparam sel_state_t ST_DRAIN    = 3'd4;
  localparam sel_state_t ST_EMIT     = 3'd5;

endpackage

// File: rtl/select_scan_ctrl.sv
// Programs a bin window into select_ram, scans all bins and streams the
// selection as 32 MSB-first mask bytes, counting the selected bins.
module select_scan_ctrl
  import select_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [SEL_AW-1:0] cfg_start,
  input  logic [SEL_AW-1:0] cfg_end,
  output logic              cfg_err,
  output logic [SEL_AW-1:0] sr_start_position,
  output logic [SEL_AW-1:0] sr_end_position,
  output logic              sr_position_wr_en,
  input  logic              sr_rd_ready,
  output logic              sr_rd_en,
  output logic [SEL_AW-1:0] sr_rd_addr,
  input  logic              sr_data_out,
  input  logic              sr_data_out_valid,
  output logic [7:0]        mask_byte,
  output logic [4:0]        mask_index,
  output logic              mask_valid,
  input  logic              mask_ready,
  output logic [SEL_CW-1:0] sel_count,
  output logic              scan_done,
  output logic              busy
);

  localparam logic [4:0] LAST_BYTE = 5'(SEL_BYTES - 1);

  sel_state_t        state_q, state_d;
  logic [4:0]        k_q, k_d;
  logic [4:0]        k_inc;
  logic [SEL_AW-1:0] addr_q, addr_d;
  logic [SEL_AW-1:0] start_q, start_d;
  logic [SEL_AW-1:0] end_q, end_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [SEL_CW-1:0] count_q, count_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              mask_valid_q, mask_valid_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic              cfg_err_q, cfg_err_d;
  logic              scan_done_q, scan_done_d;
  logic              busy_q, busy_d;
  logic              cfg_hit;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    addr_d      = addr_q;
    start_d     = start_q;
    end_d       = end_q;
    shreg_d     = shreg_q;
    count_d     = count_q;
    cfg_err_d   = 1'b0;
    scan_done_d = 1'b0;
    k_inc       = k_q + 5'd1;
    cfg_hit     = cfg_ready_q && cfg_valid;

    // RAM bits trail the read strobe by one cycle, so DRAIN still captures.
    if ((state_q == ST_READ || state_q == ST_DRAIN) && sr_data_out_valid) begin
      shreg_d = {shreg_q[6:0], sr_data_out};
      count_d = count_q + {{(SEL_CW-1){1'b0}}, sr_data_out};
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_hit) begin
          if (cfg_start > cfg_end) begin
            cfg_err_d = 1'b1;
          end else begin
            start_d = cfg_start;
            end_d   = cfg_end;
            count_d = '0;
            k_d     = '0;
            state_d = ST_CFG;
          end
        end
      end
      ST_CFG: state_d = ST_WAIT_RDY;
      ST_WAIT_RDY: begin
        if (sr_rd_ready) begin
          addr_d  = {k_q, 3'd0};
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (addr_q[2:0] == 3'd7) begin
          state_d = ST_DRAIN;
        end else begin
          addr_d = addr_q + 8'd1;
        end
      end
      ST_DRAIN: state_d = ST_EMIT;
      ST_EMIT: begin
        if (mask_ready) begin
          if (k_q == LAST_BYTE) begin
            k_d         = '0;
            scan_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            k_d     = k_inc;
            addr_d  = {k_inc, 3'd0};
            state_d = ST_READ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are registered from the next state so they line up with it.
    wr_en_d      = (state_d == ST_CFG);
    rd_en_d      = (state_d == ST_READ);
    mask_valid_d = (state_d == ST_EMIT);
    cfg_ready_d  = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      addr_q       <= '0;
      start_q      <= '0;
      end_q        <= '0;
      shreg_q      <= '0;
      count_q      <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      mask_valid_q <= 1'b0;
      cfg_ready_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
      scan_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      addr_q       <= addr_d;
      start_q      <= start_d;
      end_q        <= end_d;
      shreg_q      <= shreg_d;
      count_q      <= count_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      mask_valid_q <= mask_valid_d;
      cfg_ready_q  <= cfg_ready_d;
      cfg_err_q    <= cfg_err_d;
      scan_done_q  <= scan_done_d;
      busy_q       <= busy_d;
    end
  end

  assign cfg_ready         = cfg_ready_q;
  assign cfg_err           = cfg_err_q;
  assign sr_start_position = start_q;
  assign sr_end_position   = end_q;
  assign sr_position_wr_en = wr_en_q;
  assign sr_rd_en          = rd_en_q;
  assign sr_rd_addr        = addr_q;
  assign mask_byte         = shreg_q;
  assign mask_index        = k_q;
  assign mask_valid        = mask_valid_q;
  assign sel_count         = count_q;
  assign scan_done         = scan_done_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_select_scan_ctrl.sv
// Bench for select_scan_ctrl: behavioural select_ram stub, cycle-level
// reference model of the scan timeline, and directed plus random scenarios.
module tb_select_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_start = '0;
  logic [7:0] cfg_end = '0;
  logic       mask_ready = 1'b1;
  logic       cfg_ready, cfg_err, sr_position_wr_en, sr_rd_en, sr_rd_ready;
  logic [7:0] sr_start_position, sr_end_position, sr_rd_addr, mask_byte;
  logic       sr_data_out, sr_data_out_valid, mask_valid, scan_done, busy;
  logic [4:0] mask_index;
  logic [8:0] sel_count;

  always #5 clk = ~clk;

  select_scan_ctrl dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_err(cfg_err),
    .sr_start_position(sr_start_position), .sr_end_position(sr_end_position),
    .sr_position_wr_en(sr_position_wr_en), .sr_rd_ready(sr_rd_ready),
    .sr_rd_en(sr_rd_en), .sr_rd_addr(sr_rd_addr),
    .sr_data_out(sr_data_out), .sr_data_out_valid(sr_data_out_valid),
    .mask_byte(mask_byte), .mask_index(mask_index), .mask_valid(mask_valid),
    .mask_ready(mask_ready), .sel_count(sel_count),
    .scan_done(scan_done), .busy(busy)
  );

  // select_ram stub: bit = (S <= addr <= E), one-cycle read latency,
  // rd_ready low in the wr_en cycle and the cycle after it.
  logic       ram_ready_q, ram_wr_seen;
  logic [7:0] ram_s, ram_e;
  assign sr_rd_ready = ram_ready_q && !sr_position_wr_en;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_ready_q <= 1'b1; ram_wr_seen <= 1'b0; ram_s <= '0; ram_e <= '0;
      sr_data_out <= 1'b0; sr_data_out_valid <= 1'b0;
    end else begin
      ram_wr_seen <= sr_position_wr_en;
      if (ram_wr_seen) begin
        ram_s <= sr_start_position;
        ram_e <= sr_end_position;
      end
      ram_ready_q       <= !sr_position_wr_en;
      sr_data_out_valid <= sr_rd_en;
      sr_data_out       <= sr_rd_en && (sr_rd_addr >= ram_s) && (sr_rd_addr <= ram_e);
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] exp_byte(input int s, input int e, input int k);
    logic [7:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      r[7-j] = ((8*k + j) >= s) && ((8*k + j) <= e);
    end
    return r;
  endfunction

  // Reference model: timeline of one scan expressed in cycle numbers.
  int m_cyc = 0;
  bit m_busy = 0, m_wait = 0, m_rdy_ok = 0;
  int m_acc = -100, m_rs = -100, m_k = 0, m_s = 0, m_e = 0;
  int m_err_cyc = -100, m_done_cyc = -100, m_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_wait = 0; m_rdy_ok = 0; m_k = 0; m_cnt = 0;
      m_acc = -100; m_rs = -100; m_err_cyc = -100; m_done_cyc = -100;
    end else begin
      if (!m_busy && m_rdy_ok && cfg_valid) begin
        if (cfg_start > cfg_end) m_err_cyc = m_cyc + 1;
        else begin
          m_busy = 1; m_wait = 1; m_acc = m_cyc; m_k = 0;
          m_s = int'(cfg_start); m_e = int'(cfg_end); m_cnt = 0;
        end
      end else if (m_busy && m_wait) begin
        if (m_cyc >= m_acc + 2 && sr_rd_ready) begin
          m_wait = 0; m_rs = m_cyc + 1;
        end
      end else if (m_busy && m_cyc >= m_rs + 9 && mask_ready) begin
        if (m_k == 31) begin
          m_busy = 0; m_k = 0; m_done_cyc = m_cyc + 1; m_cnt = m_e - m_s + 1;
        end else begin
          m_k++; m_rs = m_cyc + 1;
        end
      end
      m_rdy_ok = 1;
    end
    m_cyc++;
  end

  // Observations used by the directed literal checks.
  logic [7:0] obs_byte [32];
  int  first_mv = -1, done_obs = -1, wr_cnt = 0, err_cnt = 0, rd_since_hs = 0;
  logic [7:0] wr_start = '0;
  bit  done_flag = 0;

  always @(negedge clk) begin
    int  c;
    bit  exp_rd, exp_mv;
    c = m_cyc;
    if (rst) begin
      chk("reset_ctrl", {cfg_ready, cfg_err, sr_position_wr_en, sr_rd_en,
                         mask_valid, scan_done, busy}, 0);
      chk("reset_data", {sr_start_position, sr_end_position, sr_rd_addr, mask_byte}, 0);
      chk("reset_misc", {mask_index, sel_count}, 0);
      rd_since_hs = 0;
    end else begin
      exp_rd = m_busy && !m_wait && c >= m_rs && c <= m_rs + 7;
      exp_mv = m_busy && !m_wait && c >= m_rs + 9;
      chk("busy", busy, m_busy);
      chk("cfg_ready", cfg_ready, m_rdy_ok && !m_busy);
      chk("cfg_err", cfg_err, c == m_err_cyc);
      chk("wr_en", sr_position_wr_en, m_busy && c == m_acc + 1);
      chk("rd_en", sr_rd_en, exp_rd);
      if (exp_rd) chk("rd_addr", sr_rd_addr, 8*m_k + (c - m_rs));
      chk("mask_valid", mask_valid, exp_mv);
      if (exp_mv) begin
        chk("mask_index", mask_index, m_k);
        chk("mask_byte", mask_byte, exp_byte(m_s, m_e, m_k));
      end
      chk("scan_done", scan_done, c == m_done_cyc);
      if (m_busy) begin
        chk("sr_start", sr_start_position, m_s);
        chk("sr_end", sr_end_position, m_e);
        if (c == m_acc + 1) chk("sel_count_clear", sel_count, 0);
      end else begin
        chk("sel_count_held", sel_count, m_cnt);
      end
      if (sr_rd_en) rd_since_hs++;
      if (mask_valid && first_mv < 0) first_mv = c;
      if (mask_valid && mask_ready) begin
        obs_byte[mask_index] = mask_byte;
        chk("rd_per_byte", rd_since_hs <= 8, 1);
        rd_since_hs = 0;
      end
      if (sr_position_wr_en) begin wr_cnt++; wr_start = sr_start_position; end
      if (cfg_err) err_cnt++;
      if (scan_done) begin done_obs = c; done_flag = 1; end
    end
  end

  bit rnd_ready = 0;
  always @(posedge clk) begin
    #1 mask_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  int t_acc;

  task automatic clear_obs();
    for (int i = 0; i < 32; i++) obs_byte[i] = 8'h5A;
    first_mv = -1; done_obs = -1; wr_cnt = 0; err_cnt = 0; done_flag = 0;
  endtask

  task automatic do_req(input int s, input int e);
    int n;
    clear_obs();
    n = 0;
    while (!cfg_ready && n < 1000) begin @(negedge clk); #1; n++; end
    chk("req_ready_timeout", cfg_ready, 1);
    cfg_start = 8'(s); cfg_end = 8'(e); cfg_valid = 1'b1;
    @(posedge clk); #1;
    t_acc = m_acc;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_flag && n < 6000) begin @(negedge clk); #1; n++; end
    chk("scan_done_timeout", done_flag, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Narrow window, ready tied high: exact timeline.
    rnd_ready = 0;
    do_req(10, 20);
    wait_done();
    chk("t1_byte0", obs_byte[0], 8'h00);
    chk("t1_byte1", obs_byte[1], 8'h3F);
    chk("t1_byte2", obs_byte[2], 8'hF8);
    ok = 1;
    for (int i = 3; i < 32; i++) if (obs_byte[i] !== 8'h00) ok = 0;
    chk("t1_bytes3_31_zero", ok, 1);
    chk("t1_sel_count", sel_count, 11);
    chk("t1_first_valid_cycle", first_mv - t_acc, 13);
    chk("t1_done_cycle", done_obs - t_acc, 324);
    chk("t1_wr_pulses", wr_cnt, 1);

    // Full window.
    do_req(0, 255);
    wait_done();
    ok = 1;
    for (int i = 0; i < 32; i++) if (obs_byte[i] !== 8'hFF) ok = 0;
    chk("t2_all_ff", ok, 1);
    chk("t2_sel_count", sel_count, 256);
    chk("t2_wr_pulses", wr_cnt, 1);
    chk("t2_wr_start", wr_start, 0);

    // Rejected window.
    do_req(30, 5);
    repeat (5) @(negedge clk);
    chk("t3_err_pulses", err_cnt, 1);
    chk("t3_no_wr", wr_cnt, 0);
    chk("t3_busy", busy, 0);
    chk("t3_cfg_ready", cfg_ready, 1);

    // Single bin with random back-pressure.
    rnd_ready = 1;
    do_req(100, 100);
    wait_done();
    chk("t4_byte12", obs_byte[12], 8'h08);
    chk("t4_byte11", obs_byte[11], 8'h00);
    chk("t4_sel_count", sel_count, 1);

    // Reset while byte 7 is being offered.
    do_req(3, 200);
    n = 0;
    while (!(mask_valid && mask_index == 5'd7) && n < 3000) begin @(negedge clk); #1; n++; end
    chk("t5_reached_byte7", mask_valid && mask_index == 5'd7, 1);
    #1 rst = 1'b1;
    #1;
    chk("t5_valid_drop", mask_valid, 0);
    chk("t5_busy_drop", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_req(50, 60);
    wait_done();
    chk("t5_sel_count", sel_count, 11);
    chk("t5_byte6", obs_byte[6], 8'h3F);
    chk("t5_byte7", obs_byte[7], 8'hF8);

    // cfg_valid held through a scan: next request taken right after scan_done.
    rnd_ready = 0;
    do_req(10, 20);
    cfg_start = 8'd40; cfg_end = 8'd47; cfg_valid = 1'b1;
    wait_done();
    chk("t6_first_count", sel_count, 11);
    @(posedge clk); #1;
    chk("t6_second_accept_cycle", m_acc, done_obs);
    chk("t6_second_busy", busy, 1);
    cfg_valid = 1'b0;
    clear_obs();
    wait_done();
    chk("t6_sel_count", sel_count, 8);
    chk("t6_byte5", obs_byte[5], 8'hFF);
    chk("t6_byte6", obs_byte[6], 8'h00);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
